uart_hex_display_mux: RTL and testbench
=======================================

// Module: uart_hex_display_mux
// PURPOSE
//  Parametrised successor to the single-digit UART hex display. Accepts ASCII bytes from the
//  UART receiver's byte stream, keeps the last NUM_DIGITS hex digits in a shift buffer, and
//  time-multiplexes them onto one shared 7-segment bus with per-digit anode enables.
//  Sits between uart_rx (data/done) and the board's multi-digit display pins.
// PARAMETERS
//  NUM_DIGITS     4      digits in buffer/display; legal 1..8
//  SCAN_DIV       12000  clk cycles each digit is lit (1 kHz/digit at 12 MHz); legal >= 2
//  SEG_ACTIVE_LOW 0      1: seg bits driven low = segment on
//  AN_ACTIVE_LOW  0      1: an bits driven low = digit enabled
// PORTS
//  clk        in   1              system clock, 12 MHz
//  rst        in   1              synchronous reset, active-low (rst==0 resets on clk edge)
//  rx_data    in   8              received byte from uart_rx
//  rx_valid   in   1              1-cycle strobe, rx_data valid (uart_rx done)
//  seg        out  7              segments {g,f,e,d,c,b,a} for the currently scanned digit
//  an         out  NUM_DIGITS     one-hot digit enable; an[i] = digit i (0 = rightmost)
//  hex_value  out  4*NUM_DIGITS   flattened buffer, digit i at [4i+3:4i]; blank digit reads 0
//  digit_cnt  out  $clog2(NUM_DIGITS+1)  number of non-blank digits, 0..NUM_DIGITS
//  err        out  1              sticky: last processed byte was not accepted
// BEHAVIOUR
//  State: digit[i] = {vld, nib[3:0]}; cnt; err; prescaler (0..SCAN_DIV-1); scan_idx.
//  Reset (rst==0 at clk edge): all digits blank (vld=0,nib=0), cnt=0, err=0, prescaler=0,
//   scan_idx=0. Hence an = digit 0 enabled, seg = all off, hex_value=0. Reset beats rx_valid.
//  Byte decode on rx_valid==1 (rx_valid==0: buffer/cnt/err hold):
//   '0'-'9' (0x30-0x39) -> 0..9; 'A'-'F' (0x41-0x46) and 'a'-'f' (0x61-0x66) -> 10..15.
//  Hex byte: shift left, digit[i]<=digit[i-1] for i>=1, digit[0]<={1,nib};
//   digit[NUM_DIGITS-1] is discarded; cnt<=min(cnt+1,NUM_DIGITS); err<=0.
//  Any other byte: buffer and cnt unchanged, err<=1 (held until next accepted byte or reset).
//  Latency: hex_value/digit_cnt/err reflect a byte on the clk edge after rx_valid (1 cycle).
//  Scan: prescaler counts every clk; at SCAN_DIV-1 it wraps to 0 and scan_idx advances,
//   wrapping NUM_DIGITS-1 -> 0. Each digit is lit exactly SCAN_DIV cycles per frame.
//  seg/an: combinational from registered scan_idx and digit[scan_idx]; an one-hot at scan_idx;
//   blank digit -> seg all off (polarity applied per SEG_ACTIVE_LOW). Glyphs: standard hex,
//   lower-case b and d. Decoder is internal; no external seven_seg_decoder needed.
//  Buffer update and scan advance are independent; same-cycle events both take effect, and the
//   scanned digit shows the new contents from the next cycle onwards.
//  NUM_DIGITS==1: shift replaces digit 0, an is constant enabled.
// CONFIGURATION
//  UHD_CTRL_CHARS_EN defined:
//   0x0D (CR): all digits blank, cnt=0, err=0.
//   0x08 (BS): shift right, digit[i]<=digit[i+1], digit[NUM_DIGITS-1]<=blank;
//    cnt<=cnt-1, err=0. BS with cnt==0: no change, err=0.
//  Not defined: 0x0D and 0x08 are ordinary invalid bytes (buffer held, err<=1).
// TESTING  (NUM_DIGITS=4, SCAN_DIV=4, active-high polarity)
//  Reset: hold rst=0 two cycles -> an=4'b0001, seg=0, hex_value=16'h0000, digit_cnt=0, err=0.
//  Send "1","2","a","F" -> hex_value=16'h12AF, digit_cnt=4; then "7" -> 16'h2AF7, cnt stays 4.
//  Send "G" (0x47) after "12AF" -> hex_value unchanged 16'h12AF, err=1; then "3" -> 16'h2AF3, err=0.
//  Scan: after reset an sequence 0001,0010,0100,1000,0001, each held exactly 4 cycles; with
//   buffer "5" only, seg=7'h6D while an=0001 and seg=0 on other digits.
//  With UHD_CTRL_CHARS_EN: "1","2","3",BS -> 16'h0012, cnt=2; CR -> 16'h0000, cnt=0;
//   BS on empty -> no change, err=0. Without macro: CR -> err=1, buffer unchanged.
//  Reset mid-stream: rst=0 on the same cycle as rx_valid with "9" -> all state cleared, "9" dropped.

Source files
------------

// File: rtl/uart_hex_display_mux.sv
// Multi-digit UART hex display: shifts received hex characters into a digit buffer and
// time-multiplexes it onto a shared 7-segment bus. Optional CR/BS editing via UHD_CTRL_CHARS_EN.
module uart_hex_display_mux #(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 12000,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [7:0]                      rx_data,
    input  logic                            rx_valid,
    output logic [6:0]                      seg,
    output logic [NUM_DIGITS-1:0]           an,
    output logic [4*NUM_DIGITS-1:0]         hex_value,
    output logic [$clog2(NUM_DIGITS+1)-1:0] digit_cnt,
    output logic                            err
);

    localparam int CW = $clog2(NUM_DIGITS + 1);
    localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX  = SW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(NUM_DIGITS);

    // Returns {is_hex, nibble} for an ASCII byte.
    function automatic logic [4:0] hex_decode(input logic [7:0] b);
        if (b >= 8'h30 && b <= 8'h39) begin
            return {1'b1, 4'(b - 8'h30)};
        end else if (b >= 8'h41 && b <= 8'h46) begin
            return {1'b1, 4'(b - 8'h37)};
        end else if (b >= 8'h61 && b <= 8'h66) begin
            return {1'b1, 4'(b - 8'h57)};
        end else begin
            return 5'b0_0000;
        end
    endfunction

    // Segment pattern {g,f,e,d,c,b,a}, active-high, lower-case b and d.
    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        case (n)
            4'h0:    return 7'h3F;
            4'h1:    return 7'h06;
            4'h2:    return 7'h5B;
            4'h3:    return 7'h4F;
            4'h4:    return 7'h66;
            4'h5:    return 7'h6D;
            4'h6:    return 7'h7D;
            4'h7:    return 7'h07;
            4'h8:    return 7'h7F;
            4'h9:    return 7'h6F;
            4'hA:    return 7'h77;
            4'hB:    return 7'h7C;
            4'hC:    return 7'h39;
            4'hD:    return 7'h5E;
            4'hE:    return 7'h79;
            4'hF:    return 7'h71;
            default: return 7'h00;
        endcase
    endfunction

    logic [NUM_DIGITS-1:0]       vld_r, vld_nxt_s;
    logic [NUM_DIGITS-1:0][3:0]  nib_r, nib_nxt_s;
    logic [CW-1:0]               cnt_r, cnt_nxt_s;
    logic                        err_r, err_nxt_s;
    logic [PW-1:0]               presc_r;
    logic [SW-1:0]               scan_r;
    logic [4:0]                  dec_s;
    logic [6:0]                  glyph_s;
    logic [NUM_DIGITS-1:0]       an_s;

    // Next buffer state from the received byte.
    always_comb begin
        vld_nxt_s = vld_r;
        nib_nxt_s = nib_r;
        cnt_nxt_s = cnt_r;
        err_nxt_s = err_r;
        dec_s     = hex_decode(rx_data);
        if (rx_valid) begin
            if (dec_s[4]) begin
                for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
                    vld_nxt_s[i] = vld_r[i-1];
                    nib_nxt_s[i] = nib_r[i-1];
                end
                vld_nxt_s[0] = 1'b1;
                nib_nxt_s[0] = dec_s[3:0];
                if (cnt_r == CNT_MAX) begin
                    cnt_nxt_s = cnt_r;
                end else begin
                    cnt_nxt_s = cnt_r + CW'(1);
                end
                err_nxt_s = 1'b0;
            end
`ifdef UHD_CTRL_CHARS_EN
            else if (rx_data == 8'h0D) begin
                vld_nxt_s = '0;
                nib_nxt_s = '0;
                cnt_nxt_s = '0;
                err_nxt_s = 1'b0;
            end else if (rx_data == 8'h08) begin
                // Backspace drops the most recent digit; an empty buffer is left alone.
                if (cnt_r != CW'(0)) begin
                    for (int i = 0; i < NUM_DIGITS - 1; i++) begin
                        vld_nxt_s[i] = vld_r[i+1];
                        nib_nxt_s[i] = nib_r[i+1];
                    end
                    vld_nxt_s[NUM_DIGITS-1] = 1'b0;
                    nib_nxt_s[NUM_DIGITS-1] = 4'h0;
                    cnt_nxt_s = cnt_r - CW'(1);
                end else begin
                    cnt_nxt_s = cnt_r;
                end
                err_nxt_s = 1'b0;
            end
`endif
            else begin
                err_nxt_s = 1'b1;
            end
        end else begin
            err_nxt_s = err_r;
        end
    end

    // Digit buffer, count and sticky error registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_r <= '0;
            nib_r <= '0;
            cnt_r <= '0;
            err_r <= 1'b0;
        end else begin
            vld_r <= vld_nxt_s;
            nib_r <= nib_nxt_s;
            cnt_r <= cnt_nxt_s;
            err_r <= err_nxt_s;
        end
    end

    // Scan prescaler and active digit index.
    always_ff @(posedge clk) begin
        if (!rst) begin
            presc_r <= '0;
            scan_r  <= '0;
        end else if (presc_r == PRESC_MAX) begin
            presc_r <= '0;
            if (scan_r == SCAN_MAX) begin
                scan_r <= '0;
            end else begin
                scan_r <= scan_r + SW'(1);
            end
        end else begin
            presc_r <= presc_r + PW'(1);
            scan_r  <= scan_r;
        end
    end

    // Segment and anode drive for the scanned digit, with output polarity.
    always_comb begin
        an_s = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_s[i] = (scan_r == SW'(i));
        end
        if (vld_r[scan_r]) begin
            glyph_s = hex_glyph(nib_r[scan_r]);
        end else begin
            glyph_s = 7'h00;
        end
        if (SEG_ACTIVE_LOW != 0) begin
            seg = ~glyph_s;
        end else begin
            seg = glyph_s;
        end
        if (AN_ACTIVE_LOW != 0) begin
            an = ~an_s;
        end else begin
            an = an_s;
        end
    end

    assign hex_value = nib_r;
    assign digit_cnt = cnt_r;
    assign err       = err_r;

endmodule

// File: tb/tb_uart_hex_display_mux.sv
// Randomised bench for uart_hex_display_mux (4 digits, SCAN_DIV=4) against an arithmetic
// reference model of the buffer value, digit count, error flag and scan position.
module tb_uart_hex_display_mux;
    localparam int N  = 4;
    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] hex_value;
    logic [2:0]  digit_cnt;
    logic        err;

    int checks = 0;
    int errors = 0;
    int m_val  = 0;
    int m_cnt  = 0;
    int m_tick = 0;
    int m_err  = 0;
    logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    uart_hex_display_mux #(
        .NUM_DIGITS(N), .SCAN_DIV(SD), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)
    ) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .seg(seg), .an(an), .hex_value(hex_value), .digit_cnt(digit_cnt), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int hex_of(input int b);
        if (b >= 48 && b <= 57)  return b - 48;
        if (b >= 65 && b <= 70)  return b - 55;
        if (b >= 97 && b <= 102) return b - 87;
        return -1;
    endfunction

    task automatic model_byte(input int b);
        int n;
        n = hex_of(b);
        if (n >= 0) begin
            m_val = (m_val * 16 + n) % 65536;
            m_cnt = (m_cnt < N) ? m_cnt + 1 : N;
            m_err = 0;
        end
`ifdef UHD_CTRL_CHARS_EN
        else if (b == 13) begin
            m_val = 0; m_cnt = 0; m_err = 0;
        end else if (b == 8) begin
            if (m_cnt > 0) begin
                m_val = m_val / 16;
                m_cnt = m_cnt - 1;
            end
            m_err = 0;
        end
`endif
        else begin
            m_err = 1;
        end
    endtask

    task automatic check_all();
        int idx;
        int d;
        logic [6:0] es;
        idx = (m_tick / SD) % N;
        d   = (m_val >> (4 * idx)) & 15;
        es  = (idx < m_cnt) ? glyph_tab[d] : 7'h00;
        check("hex_value", 32'(hex_value), 32'(m_val));
        check("digit_cnt", 32'(digit_cnt), 32'(m_cnt));
        check("err", 32'(err), 32'(m_err));
        check("an", 32'(an), 32'(1 << idx));
        check("seg", 32'(seg), 32'(es));
    endtask

    // One clock: drive inputs, advance the model at the edge, check at the falling edge.
    task automatic step(input logic [7:0] b, input logic v, input logic r);
        rx_data  = b;
        rx_valid = v;
        rst      = r;
        @(posedge clk);
        if (!r) begin
            m_val = 0; m_cnt = 0; m_err = 0; m_tick = 0;
        end else begin
            m_tick++;
            if (v) model_byte(int'(b));
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        step(8'h00, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        string hs;
        logic [7:0] b;
        logic       v;
        logic       r;
        hs = "0123456789ABCDEFabcdef";

        do_reset();
        check("rst_an", 32'(an), 32'h1);
        check("rst_seg", 32'(seg), 32'h0);
        check("rst_hex", 32'(hex_value), 32'h0);

        step("1", 1'b1, 1'b1); step("2", 1'b1, 1'b1);
        step("a", 1'b1, 1'b1); step("F", 1'b1, 1'b1);
        check("hex_12AF", 32'(hex_value), 32'h12AF);
        check("cnt_full", 32'(digit_cnt), 32'd4);
        step("7", 1'b1, 1'b1);
        check("hex_2AF7", 32'(hex_value), 32'h2AF7);
        check("cnt_sat", 32'(digit_cnt), 32'd4);

        do_reset();
        step("1", 1'b1, 1'b1); step("2", 1'b1, 1'b1);
        step("A", 1'b1, 1'b1); step("F", 1'b1, 1'b1);
        step(8'h47, 1'b1, 1'b1);
        check("bad_hold", 32'(hex_value), 32'h12AF);
        check("bad_err", 32'(err), 32'h1);
        step(8'h00, 1'b0, 1'b1);
        check("err_sticky", 32'(err), 32'h1);
        step("3", 1'b1, 1'b1);
        check("hex_2AF3", 32'(hex_value), 32'h2AF3);
        check("err_clr", 32'(err), 32'h0);
`ifdef UHD_CTRL_CHARS_EN
        do_reset();
        step("1", 1'b1, 1'b1); step("2", 1'b1, 1'b1); step("3", 1'b1, 1'b1);
        step(8'h08, 1'b1, 1'b1);
        check("bs_hex", 32'(hex_value), 32'h0012);
        check("bs_cnt", 32'(digit_cnt), 32'd2);
        step(8'h0D, 1'b1, 1'b1);
        check("cr_hex", 32'(hex_value), 32'h0);
        check("cr_cnt", 32'(digit_cnt), 32'd0);
        step(8'h08, 1'b1, 1'b1);
        check("bs_empty_hex", 32'(hex_value), 32'h0);
        check("bs_empty_err", 32'(err), 32'h0);
`else
        step(8'h0D, 1'b1, 1'b1);
        check("cr_err", 32'(err), 32'h1);
        check("cr_hold", 32'(hex_value), 32'h2AF3);
`endif

        do_reset();
        step("5", 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step(8'h00, 1'b0, 1'b1);
            if (an == 4'b0001) check("seg_5", 32'(seg), 32'h6D);
            else               check("seg_off", 32'(seg), 32'h0);
        end

        step("4", 1'b1, 1'b1);
        step("9", 1'b1, 1'b0);
        check("rst_mid_hex", 32'(hex_value), 32'h0);
        check("rst_mid_cnt", 32'(digit_cnt), 32'd0);

        for (int i = 0; i < 800; i++) begin
            r = ($urandom_range(0, 99) != 0);
            v = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0, 1:    b = hs[$urandom_range(0, 21)];
                2:       b = ($urandom_range(0, 1) != 0) ? 8'h0D : 8'h08;
                default: b = 8'($urandom_range(0, 255));
            endcase
            step(b, v, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
